qspi_bus_arbiter: RTL and testbench



---
 rtl/qspi_arb_pkg.sv | 17 +
 rtl/qspi_arb_pick.sv | 27 ++
 rtl/qspi_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_qspi_bus_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/qspi_arb_pkg.sv
// Shared types for the QSPI bus arbiter: FSM states, owner encodings, TURN counter width.
package qspi_arb_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_NOR = 2'd1,
        GNT_RAM = 2'd2,
        TURN    = 2'd3
    } state_e;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_NOR  = 2'b01;
    localparam logic [1:0] OWNER_RAM  = 2'b10;

endpackage

// File: rtl/qspi_arb_pick.sv
// Combinational tie-break between NOR and PSRAM requests.
// QSPI_ARB_ROUND_ROBIN_EN selects round-robin; otherwise NOR has fixed priority.
module qspi_arb_pick (
    input  logic nor_req_i,
    input  logic ram_req_i,
    input  logic ram_pref_i,
    output logic pick_nor_o,
    output logic pick_ram_o
);

`ifdef QSPI_ARB_ROUND_ROBIN_EN
    // ram_pref_i high means NOR was granted last, so PSRAM wins a tie.
    always_comb begin
        pick_nor_o = nor_req_i & (~ram_req_i | ~ram_pref_i);
        pick_ram_o = ram_req_i & (~nor_req_i |  ram_pref_i);
    end
`else
    logic unused_ptr;

    always_comb begin
        unused_ptr = ram_pref_i;
        pick_nor_o = nor_req_i;
        pick_ram_o = ram_req_i & ~nor_req_i;
    end
`endif

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Shares one 4-bit QSPI data bus between the NOR fetch and PSRAM controllers with idle turnaround.
// Define QSPI_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed NOR priority.
module qspi_bus_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       nor_req,
    output logic       nor_gnt,
    input  logic       nor_ce,
    input  logic       nor_sclk,
    input  logic [3:0] nor_sio_o,
    input  logic [3:0] nor_sio_oe,
    output logic [3:0] nor_sio_i,

    input  logic       ram_req,
    output logic       ram_gnt,
    input  logic       ram_ce,
    input  logic       ram_sclk,
    input  logic [3:0] ram_sio_o,
    input  logic [3:0] ram_sio_oe,
    output logic [3:0] ram_sio_i,

    output logic       ce0,
    output logic       sclk_ram,
    output logic       ce1,
    output logic       sclk_nor,
    output logic [3:0] sio_o,
    output logic [3:0] sio_oe,
    input  logic [3:0] sio_i,
    output logic [1:0] owner
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               arb_point;
    logic               pick_nor, pick_ram;
    logic               ram_pref;

    qspi_arb_pick u_pick (
        .nor_req_i  (nor_req),
        .ram_req_i  (ram_req),
        .ram_pref_i (ram_pref),
        .pick_nor_o (pick_nor),
        .pick_ram_o (pick_ram)
    );

`ifdef QSPI_ARB_ROUND_ROBIN_EN
    logic ram_pref_q, ram_pref_d;

    // Last-owner pointer: set after a NOR grant, cleared after a PSRAM grant.
    always_comb begin
        ram_pref_d = ram_pref_q;
        if (arb_point && pick_nor) begin
            ram_pref_d = 1'b1;
        end else if (arb_point && pick_ram) begin
            ram_pref_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_pref_q <= 1'b0;
        end else begin
            ram_pref_q <= ram_pref_d;
        end
    end

    assign ram_pref = ram_pref_q;
`else
    assign ram_pref = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arb_point = (state_q == IDLE) || ((state_q == TURN) && (cnt_q == '0));

        nor_gnt   = 1'b0;
        ram_gnt   = 1'b0;
        owner     = OWNER_NONE;
        ce0       = 1'b1;
        ce1       = 1'b1;
        sclk_ram  = 1'b0;
        sclk_nor  = 1'b0;
        sio_o     = 4'h0;
        sio_oe    = 4'h0;
        nor_sio_i = 4'h0;
        ram_sio_i = 4'h0;

        case (state_q)
            GNT_NOR: begin
                if (!nor_req) begin
                    state_d = TURN;
                    cnt_d   = CNT_W'(TURN_CYCLES - 1);
                end
            end
            GNT_RAM: begin
                if (!ram_req) begin
                    state_d = TURN;
                    cnt_d   = CNT_W'(TURN_CYCLES - 1);
                end
            end
            TURN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase

        if (arb_point) begin
            if (pick_nor) begin
                state_d = GNT_NOR;
            end else if (pick_ram) begin
                state_d = GNT_RAM;
            end else begin
                state_d = IDLE;
            end
        end

        // Pins follow the registered owner only; everything else stays released.
        if (state_q == GNT_NOR) begin
            nor_gnt   = 1'b1;
            owner     = OWNER_NOR;
            ce1       = nor_ce;
            sclk_nor  = nor_sclk;
            sio_o     = nor_sio_o;
            sio_oe    = nor_sio_oe;
            nor_sio_i = sio_i;
        end else if (state_q == GNT_RAM) begin
            ram_gnt   = 1'b1;
            owner     = OWNER_RAM;
            ce0       = ram_ce;
            sclk_ram  = ram_sclk;
            sio_o     = ram_sio_o;
            sio_oe    = ram_sio_oe;
            ram_sio_i = sio_i;
        end
    end

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Self-checking bench for qspi_bus_arbiter (TURN_CYCLES = 2); honours QSPI_ARB_ROUND_ROBIN_EN.
module tb_qspi_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       nor_req, nor_gnt, nor_ce, nor_sclk;
    logic [3:0] nor_sio_o, nor_sio_oe, nor_sio_i;
    logic       ram_req, ram_gnt, ram_ce, ram_sclk;
    logic [3:0] ram_sio_o, ram_sio_oe, ram_sio_i;
    logic       ce0, sclk_ram, ce1, sclk_nor;
    logic [3:0] sio_o, sio_oe, sio_i;
    logic [1:0] owner;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    qspi_bus_arbiter #(.TURN_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .nor_req    (nor_req),
        .nor_gnt    (nor_gnt),
        .nor_ce     (nor_ce),
        .nor_sclk   (nor_sclk),
        .nor_sio_o  (nor_sio_o),
        .nor_sio_oe (nor_sio_oe),
        .nor_sio_i  (nor_sio_i),
        .ram_req    (ram_req),
        .ram_gnt    (ram_gnt),
        .ram_ce     (ram_ce),
        .ram_sclk   (ram_sclk),
        .ram_sio_o  (ram_sio_o),
        .ram_sio_oe (ram_sio_oe),
        .ram_sio_i  (ram_sio_i),
        .ce0        (ce0),
        .sclk_ram   (sclk_ram),
        .ce1        (ce1),
        .sclk_nor   (sclk_nor),
        .sio_o      (sio_o),
        .sio_oe     (sio_oe),
        .sio_i      (sio_i),
        .owner      (owner)
    );

    typedef struct {
        logic       nreq, rreq, nce, nsclk;
        logic [3:0] nso, noe;
        logic       rce, rsclk;
        logic [3:0] rso, roe, sioi;
        logic [1:0] owner;
        logic       ngnt, rgnt, ce0, ce1, sn, sr;
        logic [3:0] so, soe, nsi, rsi;
    } vec_t;

    localparam int NV = 17;
    vec_t vec [NV];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [23:0] out_bundle();
        return {owner, nor_gnt, ram_gnt, ce0, ce1, sclk_nor, sclk_ram, sio_o, sio_oe, nor_sio_i, ram_sio_i};
    endfunction

    localparam logic [23:0] IDLE_OUT = {2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};

    logic [1:0] exp_owner [4];
    int         gap, k;

    initial begin
        // nreq rreq nce nsclk nso noe | rce rsclk rso roe sioi || owner ngnt rgnt ce0 ce1 sn sr so soe nsi rsi
        vec[0]  = '{0,0,1,0,4'h0,4'h0, 1,0,4'h0,4'h0,4'h5, 2'd0,0,0,1,1,0,0,4'h0,4'h0,4'h0,4'h0};
        vec[1]  = '{1,0,1,0,4'h3,4'hF, 1,0,4'h0,4'h0,4'h5, 2'd1,1,0,1,1,0,0,4'h3,4'hF,4'h5,4'h0};
        vec[2]  = '{1,0,0,1,4'hA,4'hF, 0,1,4'h5,4'hF,4'h6, 2'd1,1,0,1,0,1,0,4'hA,4'hF,4'h6,4'h0};
        vec[3]  = '{1,0,1,0,4'h0,4'h0, 1,0,4'h0,4'h0,4'h6, 2'd1,1,0,1,1,0,0,4'h0,4'h0,4'h6,4'h0};
        vec[4]  = '{0,1,1,0,4'h0,4'h0, 1,0,4'h0,4'h0,4'h6, 2'd0,0,0,1,1,0,0,4'h0,4'h0,4'h0,4'h0};
        vec[5]  = '{0,1,1,0,4'h0,4'h0, 1,0,4'h0,4'h0,4'h6, 2'd0,0,0,1,1,0,0,4'h0,4'h0,4'h0,4'h0};
        vec[6]  = '{0,1,1,0,4'hF,4'hF, 0,1,4'h9,4'h3,4'hA, 2'd2,0,1,0,1,0,1,4'h9,4'h3,4'h0,4'hA};
        vec[7]  = '{0,0,1,0,4'hF,4'hF, 0,1,4'h9,4'hF,4'hA, 2'd0,0,0,1,1,0,0,4'h0,4'h0,4'h0,4'h0};
        vec[8]  = '{0,0,1,0,4'h0,4'h0, 1,0,4'h0,4'h0,4'hA, 2'd0,0,0,1,1,0,0,4'h0,4'h0,4'h0,4'h0};
        vec[9]  = '{0,0,1,0,4'h0,4'h0, 1,0,4'h0,4'h0,4'hA, 2'd0,0,0,1,1,0,0,4'h0,4'h0,4'h0,4'h0};
        vec[10] = '{1,1,1,0,4'h0,4'h0, 1,0,4'h0,4'h0,4'h3, 2'd1,1,0,1,1,0,0,4'h0,4'h0,4'h3,4'h0};
        vec[11] = '{0,1,1,0,4'h0,4'h0, 1,0,4'h0,4'h0,4'h3, 2'd0,0,0,1,1,0,0,4'h0,4'h0,4'h0,4'h0};
        vec[12] = '{0,1,1,0,4'h0,4'h0, 1,0,4'h0,4'h0,4'h3, 2'd0,0,0,1,1,0,0,4'h0,4'h0,4'h0,4'h0};
        vec[13] = '{0,1,1,0,4'h0,4'h0, 1,0,4'h0,4'h0,4'h3, 2'd2,0,1,1,1,0,0,4'h0,4'h0,4'h0,4'h3};
        vec[14] = '{0,0,1,0,4'h0,4'h0, 1,0,4'h0,4'h0,4'h3, 2'd0,0,0,1,1,0,0,4'h0,4'h0,4'h0,4'h0};
        vec[15] = '{0,0,1,0,4'h0,4'h0, 1,0,4'h0,4'h0,4'h3, 2'd0,0,0,1,1,0,0,4'h0,4'h0,4'h0,4'h0};
        vec[16] = '{0,0,1,0,4'h0,4'h0, 1,0,4'h0,4'h0,4'h3, 2'd0,0,0,1,1,0,0,4'h0,4'h0,4'h0,4'h0};

`ifdef QSPI_ARB_ROUND_ROBIN_EN
        exp_owner[0] = 2'd1; exp_owner[1] = 2'd2; exp_owner[2] = 2'd1; exp_owner[3] = 2'd2;
`else
        exp_owner[0] = 2'd1; exp_owner[1] = 2'd1; exp_owner[2] = 2'd1; exp_owner[3] = 2'd1;
`endif

        rst_n = 1'b0;
        nor_req = 0; nor_ce = 1; nor_sclk = 0; nor_sio_o = 0; nor_sio_oe = 0;
        ram_req = 0; ram_ce = 1; ram_sclk = 0; ram_sio_o = 0; ram_sio_oe = 0;
        sio_i = 4'h0;
        repeat (2) step();
        check("reset_outputs", 32'(out_bundle()), 32'(IDLE_OUT));
        rst_n = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            nor_req = vec[i].nreq; ram_req = vec[i].rreq;
            nor_ce = vec[i].nce; nor_sclk = vec[i].nsclk;
            nor_sio_o = vec[i].nso; nor_sio_oe = vec[i].noe;
            ram_ce = vec[i].rce; ram_sclk = vec[i].rsclk;
            ram_sio_o = vec[i].rso; ram_sio_oe = vec[i].roe;
            sio_i = vec[i].sioi;
            step();
            check($sformatf("vec%0d", i), 32'(out_bundle()),
                  32'({vec[i].owner, vec[i].ngnt, vec[i].rgnt, vec[i].ce0, vec[i].ce1,
                       vec[i].sn, vec[i].sr, vec[i].so, vec[i].soe, vec[i].nsi, vec[i].rsi}));
        end

        // Both requesters hold req; each owner releases for one cycle after 5 owned cycles.
        nor_req = 1; ram_req = 1;
        step();
        gap = 0;
        for (int g = 0; g < 4; g++) begin
            k = 0;
            while (owner == 2'd0 && k < 10) begin
                step();
                k++;
                if (owner == 2'd0) gap++;
            end
            check($sformatf("alt_owner%0d", g), 32'(owner), 32'(exp_owner[g]));
            if (g > 0) check($sformatf("alt_gap%0d", g), 32'(gap), 32'd2);
            repeat (4) step();
            if (owner == 2'd1) nor_req = 0;
            else ram_req = 0;
            step();
            nor_req = 1; ram_req = 1;
            gap = 1;
        end
        nor_req = 0; ram_req = 0;
        repeat (4) step();
        check("alt_idle", 32'(owner), 32'd0);

        // Asynchronous reset mid-burst releases the bus before the next edge.
        nor_req = 1; nor_ce = 0; nor_sio_o = 4'h5; nor_sio_oe = 4'hF;
        step();
        check("burst_gnt", 32'({nor_gnt, ce1, sio_oe}), 32'({1'b1, 1'b0, 4'hF}));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 32'({nor_gnt, ce1, sio_oe, owner}), 32'({1'b0, 1'b1, 4'h0, 2'b00}));
        nor_req = 0; nor_ce = 1; nor_sio_o = 0; nor_sio_oe = 0;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_idle", 32'(out_bundle()), 32'(IDLE_OUT));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
